// File: rtl/imm_extend_unit.sv
// rtl/imm_extend_unit.sv - immediate extension unit with 1-cycle registered output and skid entry
module imm_extend_unit #(
    parameter int IN_WIDTH   = 16,
    parameter int JUMP_WIDTH = 26,
    parameter int OUT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [JUMP_WIDTH-1:0] value,
    input  logic [2:0]            mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_value,
    output logic                  out_err
);

    localparam logic [2:0] MODE_SIGN   = 3'b000;
    localparam logic [2:0] MODE_ZERO   = 3'b001;
    localparam logic [2:0] MODE_LUI    = 3'b010;
    localparam logic [2:0] MODE_BRANCH = 3'b011;
    localparam logic [2:0] MODE_JUMP   = 3'b100;

    logic [IN_WIDTH-1:0]  imm;
    logic [OUT_WIDTH-1:0] sign_ext;
    logic [OUT_WIDTH-1:0] jump_ext;
    logic [OUT_WIDTH-1:0] ext_value;
    logic                 ext_err;

    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_value_q, out_value_d;
    logic                 out_err_q,   out_err_d;
    logic                 skid_full_q, skid_full_d;
    logic [OUT_WIDTH-1:0] skid_value_q, skid_value_d;
    logic                 skid_err_q,   skid_err_d;

    logic in_fire;
    logic out_free;

    always_comb begin
        imm       = value[IN_WIDTH-1:0];
        sign_ext  = {{(OUT_WIDTH-IN_WIDTH){imm[IN_WIDTH-1]}}, imm};
        jump_ext  = '0;
        jump_ext[JUMP_WIDTH-1:0] = value;
        ext_value = '0;
        ext_err   = 1'b0;
        case (mode)
            MODE_SIGN:   ext_value = sign_ext;
            MODE_ZERO:   ext_value = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, imm};
            MODE_LUI:    ext_value = {imm, {(OUT_WIDTH-IN_WIDTH){1'b0}}};
            MODE_BRANCH: ext_value = sign_ext << 2;
            MODE_JUMP:   ext_value = jump_ext << 2;
            default:     ext_err   = 1'b1;
        endcase
    end

    // in_ready depends only on the skid flop, so out_ready never reaches it combinationally
    assign in_ready = ~skid_full_q;
    assign in_fire  = in_valid & ~skid_full_q;
    assign out_free = ~out_valid_q | out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_value_d  = out_value_q;
        out_err_d    = out_err_q;
        skid_full_d  = skid_full_q;
        skid_value_d = skid_value_q;
        skid_err_d   = skid_err_q;
        if (out_free) begin
            if (skid_full_q) begin
                out_valid_d = 1'b1;
                out_value_d = skid_value_q;
                out_err_d   = skid_err_q;
                skid_full_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_value_d = ext_value;
                out_err_d   = ext_err;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_full_d  = 1'b1;
            skid_value_d = ext_value;
            skid_err_d   = ext_err;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_value_q  <= '0;
            out_err_q    <= 1'b0;
            skid_full_q  <= 1'b0;
            skid_value_q <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_value_q  <= out_value_d;
            out_err_q    <= out_err_d;
            skid_full_q  <= skid_full_d;
            skid_value_q <= skid_value_d;
            skid_err_q   <= skid_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb/tb_imm_extend_unit.sv - directed table-driven bench for imm_extend_unit
module tb_imm_extend_unit;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] value;
    logic [2:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic        out_err;

    logic        in_valid8;
    logic        in_ready8;
    logic [11:0] value8;
    logic [2:0]  mode8;
    logic        out_valid8;
    logic        out_ready8;
    logic [15:0] out_value8;
    logic        out_err8;

    int total;
    int bad;

    imm_extend_unit u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .value     (value),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_err   (out_err)
    );

    imm_extend_unit #(.IN_WIDTH(8), .JUMP_WIDTH(12), .OUT_WIDTH(16)) u_dut8 (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .value     (value8),
        .mode      (mode8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_value (out_value8),
        .out_err   (out_err8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  mode;
        logic [25:0] value;
        logic [31:0] exp_value;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{3'b000, 26'h0008001, 32'hFFFF8001, 1'b0};
        vecs[1]  = '{3'b001, 26'h0008001, 32'h00008001, 1'b0};
        vecs[2]  = '{3'b010, 26'h0001234, 32'h12340000, 1'b0};
        vecs[3]  = '{3'b011, 26'h000FFFF, 32'hFFFFFFFC, 1'b0};
        vecs[4]  = '{3'b100, 26'h3FFFFFF, 32'h0FFFFFFC, 1'b0};
        vecs[5]  = '{3'b101, 26'h0001234, 32'h00000000, 1'b1};
        vecs[6]  = '{3'b110, 26'h0001234, 32'h00000000, 1'b1};
        vecs[7]  = '{3'b111, 26'h3FFFFFF, 32'h00000000, 1'b1};
        vecs[8]  = '{3'b000, 26'h3FF7FFF, 32'h00007FFF, 1'b0};
        vecs[9]  = '{3'b011, 26'h0000001, 32'h00000004, 1'b0};
        vecs[10] = '{3'b011, 26'h0008000, 32'hFFFE0000, 1'b0};
        vecs[11] = '{3'b010, 26'h3FFFFFF, 32'hFFFF0000, 1'b0};
        vecs[12] = '{3'b100, 26'h0000001, 32'h00000004, 1'b0};
        vecs[13] = '{3'b001, 26'h3FFFFFF, 32'h0000FFFF, 1'b0};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        value     = '0;
        mode      = '0;
        out_ready = 1'b1;
        in_valid8 = 1'b0;
        value8    = '0;
        mode8     = '0;
        out_ready8 = 1'b1;

        #2;
        check("reset_out_valid", {31'b0, out_valid}, 32'h0);
        check("reset_out_value", out_value, 32'h0);
        check("reset_out_err",   {31'b0, out_err}, 32'h0);
        check("reset_in_ready",  {31'b0, in_ready}, 32'h1);
        step();
        step();
        reset_n = 1'b1;

        // mode table, one transfer at a time with the output always drained
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            mode     = vecs[i].mode;
            value    = vecs[i].value;
            check($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, 32'h1);
            step();
            in_valid = 1'b0;
            check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, 32'h1);
            check($sformatf("vec%0d_out_value", i), out_value, vecs[i].exp_value);
            check($sformatf("vec%0d_out_err", i), {31'b0, out_err}, {31'b0, vecs[i].exp_err});
            step();
            check($sformatf("vec%0d_drained", i), {31'b0, out_valid}, 32'h0);
        end

        // backpressure: fill both entries, then prove input is ignored when full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        mode      = 3'b000;
        value     = 26'h1;
        step();
        check("bp_first_valid", {31'b0, out_valid}, 32'h1);
        check("bp_ready_after_first", {31'b0, in_ready}, 32'h1);
        mode  = 3'b001;
        value = 26'h2;
        step();
        check("bp_ready_full", {31'b0, in_ready}, 32'h0);
        check("bp_held_value", out_value, 32'h1);
        mode  = 3'b000;
        value = 26'h3;
        step();
        check("bp_ignored_ready", {31'b0, in_ready}, 32'h0);
        check("bp_ignored_value", out_value, 32'h1);
        out_ready = 1'b1;
        step();
        check("bp_second_valid", {31'b0, out_valid}, 32'h1);
        check("bp_second_value", out_value, 32'h2);
        check("bp_ready_reopens", {31'b0, in_ready}, 32'h1);
        in_valid = 1'b0;
        step();
        check("bp_no_dup_or_extra", {31'b0, out_valid}, 32'h0);

        // streaming at full rate
        out_ready = 1'b1;
        mode      = 3'b001;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            value    = 26'(32'h10 + i);
            check($sformatf("stream%0d_in_ready", i), {31'b0, in_ready}, 32'h1);
            step();
            check($sformatf("stream%0d_valid", i), {31'b0, out_valid}, 32'h1);
            check($sformatf("stream%0d_value", i), out_value, 32'h10 + i);
        end
        in_valid = 1'b0;
        step();
        check("stream_end_empty", {31'b0, out_valid}, 32'h0);

        // reset with both entries held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        mode      = 3'b000;
        value     = 26'h5;
        step();
        value = 26'h6;
        step();
        in_valid = 1'b0;
        check("rst_pre_full", {31'b0, in_ready}, 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_in_ready",  {31'b0, in_ready}, 32'h1);
        check("rst_out_value", out_value, 32'h0);
        #2;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_no_stale%0d", i), {31'b0, out_valid}, 32'h0);
        end

        // narrow parameter variant
        mode8 = 3'b000; value8 = 12'h080; in_valid8 = 1'b1;
        step();
        check("p8_sign", {16'h0, out_value8}, 32'h0000FF80);
        mode8 = 3'b010; value8 = 12'h0AB;
        step();
        check("p8_lui", {16'h0, out_value8}, 32'h0000AB00);
        mode8 = 3'b100; value8 = 12'hFFF;
        step();
        check("p8_jump", {16'h0, out_value8}, 32'h00003FFC);
        check("p8_err", {31'b0, out_err8}, 32'h0);
        in_valid8 = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
